// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared constants for the MEM/WB stage: state encoding, datapath widths, bundle widths
package mips_pipe_pkg;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
  localparam logic [STATE_W-1:0] ST_WAIT = 1'b1;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Control half of the MEM/WB bundle: regwrite + memtoreg
  localparam int WB_CTRL_W = 2;

endpackage

// File: rtl/mem_wb_ctrl_fsm.sv
// rtl/mem_wb_ctrl_fsm.sv - IDLE/WAIT sequencer for the data-memory access; optional WAIT timeout via MEM_WB_TIMEOUT_EN
module mem_wb_ctrl_fsm
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_mem_valid,
  input  logic mem_op,
  input  logic flush,
  input  logic dmem_ready,
  output logic idle,
  output logic start_access,
  output logic finish_access,
  output logic finish_live,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_err
);

  logic [STATE_W-1:0] state;
  logic               killed;
  logic               in_wait;
  logic               timeout;

  assign in_wait       = (state == ST_WAIT);
  assign idle          = !in_wait;
  assign start_access  = !in_wait && ex_mem_valid && !flush && mem_op;
  assign finish_access = in_wait && dmem_ready;
  // A flush arriving with ready still kills the retiring instruction
  assign finish_live   = finish_access && !killed && !flush;
  assign dmem_req      = in_wait;
  assign mem_stall     = in_wait;

`ifdef MEM_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout = in_wait && !dmem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign mem_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout;
      if (start_access)
        wait_cnt <= '0;
      else if (in_wait)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      killed <= 1'b0;
    end else if (!in_wait) begin
      if (start_access) begin
        state  <= ST_WAIT;
        killed <= 1'b0;
      end
    end else begin
      // The access runs to completion even when flushed so stores never tear
      if (finish_access || timeout)
        state <= ST_IDLE;
      else if (flush)
        killed <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage and MEM/WB register with req/ready data-memory access (MEM_WB_TIMEOUT_EN enables WAIT timeout)
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_valid,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_memtoreg,
  input  logic                  ex_mem_memread,
  input  logic                  ex_mem_memwrite,
  input  logic [DATA_W-1:0]     ex_mem_alu_result,
  input  logic [DATA_W-1:0]     ex_mem_write_data,
  input  logic [REG_ADDR_W-1:0] ex_mem_dest_reg,
  input  logic                  flush,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  mem_stall,
  output logic                  MEM_WB_valid,
  output logic                  reg_write_pause,
  output logic                  MEM_WB_memtoreg,
  output logic [DATA_W-1:0]     MEM_WB_read_data,
  output logic [DATA_W-1:0]     MEM_WB_alu_result,
  output logic [REG_ADDR_W-1:0] MEM_WB_dest_reg,
  output logic                  mem_err
);

  logic                  idle;
  logic                  start_access;
  logic                  finish_access;
  logic                  finish_live;
  logic                  mem_op;
  logic [WB_CTRL_W-1:0]  lat_ctrl;
  logic [REG_ADDR_W-1:0] lat_dest;

  assign mem_op = ex_mem_memread || ex_mem_memwrite;

  mem_wb_ctrl_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_valid (ex_mem_valid),
    .mem_op       (mem_op),
    .flush        (flush),
    .dmem_ready   (dmem_ready),
    .idle         (idle),
    .start_access (start_access),
    .finish_access(finish_access),
    .finish_live  (finish_live),
    .dmem_req     (dmem_req),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      lat_ctrl          <= '0;
      lat_dest          <= '0;
      MEM_WB_valid      <= 1'b0;
      reg_write_pause   <= 1'b0;
      MEM_WB_memtoreg   <= 1'b0;
      MEM_WB_read_data  <= '0;
      MEM_WB_alu_result <= '0;
      MEM_WB_dest_reg   <= '0;
    end else begin
      MEM_WB_valid    <= 1'b0;
      reg_write_pause <= 1'b0;
      if (idle) begin
        if (start_access) begin
          dmem_we    <= ex_mem_memwrite;
          dmem_addr  <= ex_mem_alu_result;
          dmem_wdata <= ex_mem_write_data;
          lat_ctrl   <= {ex_mem_regwrite, ex_mem_memtoreg};
          lat_dest   <= ex_mem_dest_reg;
        end else if (ex_mem_valid && !flush) begin
          MEM_WB_valid      <= 1'b1;
          reg_write_pause   <= ex_mem_regwrite && (ex_mem_dest_reg != '0);
          MEM_WB_memtoreg   <= ex_mem_memtoreg;
          MEM_WB_alu_result <= ex_mem_alu_result;
          MEM_WB_dest_reg   <= ex_mem_dest_reg;
        end
      end else if (finish_access) begin
        if (!dmem_we)
          MEM_WB_read_data <= dmem_rdata;
        MEM_WB_valid      <= finish_live;
        reg_write_pause   <= finish_live && lat_ctrl[1] && (lat_dest != '0);
        MEM_WB_memtoreg   <= lat_ctrl[0];
        MEM_WB_alu_result <= dmem_addr;
        MEM_WB_dest_reg   <= lat_dest;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, ex_mem_regwrite, ex_mem_memtoreg, ex_mem_memread, ex_mem_memwrite;
  logic [31:0] ex_mem_alu_result, ex_mem_write_data;
  logic [4:0]  ex_mem_dest_reg;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall, MEM_WB_valid, reg_write_pause, MEM_WB_memtoreg;
  logic [31:0] MEM_WB_read_data, MEM_WB_alu_result;
  logic [4:0]  MEM_WB_dest_reg;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYC(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_mem_valid     (ex_mem_valid),
    .ex_mem_regwrite  (ex_mem_regwrite),
    .ex_mem_memtoreg  (ex_mem_memtoreg),
    .ex_mem_memread   (ex_mem_memread),
    .ex_mem_memwrite  (ex_mem_memwrite),
    .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_write_data(ex_mem_write_data),
    .ex_mem_dest_reg  (ex_mem_dest_reg),
    .flush            (flush),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_ready       (dmem_ready),
    .mem_stall        (mem_stall),
    .MEM_WB_valid     (MEM_WB_valid),
    .reg_write_pause  (reg_write_pause),
    .MEM_WB_memtoreg  (MEM_WB_memtoreg),
    .MEM_WB_read_data (MEM_WB_read_data),
    .MEM_WB_alu_result(MEM_WB_alu_result),
    .MEM_WB_dest_reg  (MEM_WB_dest_reg),
    .mem_err          (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
    ex_mem_valid      = v;
    ex_mem_regwrite   = rw;
    ex_mem_memtoreg   = m2r;
    ex_mem_memread    = rd;
    ex_mem_memwrite   = wr;
    ex_mem_alu_result = alu;
    ex_mem_write_data = wd;
    ex_mem_dest_reg   = dst;
  endtask

  initial begin
    // Reset must win over a live load on the inputs
    rst = 1'b1; flush = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    drive(1, 1, 1, 1, 0, 32'h44, 32'h55, 5'd9);
    tick(); tick();
    chk("rst_valid", MEM_WB_valid, 0);
    chk("rst_rwp", reg_write_pause, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_alu", MEM_WB_alu_result, 0);
    chk("rst_err", mem_err, 0);

    // ADD $3 <- 0x10
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd3);
    tick();
    chk("add_valid", MEM_WB_valid, 1);
    chk("add_rwp", reg_write_pause, 1);
    chk("add_alu", MEM_WB_alu_result, 32'h10);
    chk("add_dest", MEM_WB_dest_reg, 3);
    chk("add_req", dmem_req, 0);

    // Idle: bubble, data held
    drive(0, 0, 0, 0, 0, 32'h99, 32'h0, 5'd1);
    tick();
    chk("idle_valid", MEM_WB_valid, 0);
    chk("idle_rwp", reg_write_pause, 0);
    chk("idle_alu_hold", MEM_WB_alu_result, 32'h10);

    // LW $5 <- [0x40], ready in third WAIT cycle
    drive(1, 1, 1, 1, 0, 32'h40, 32'h0, 5'd5);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      chk($sformatf("lw_stall%0d", c), mem_stall, 1);
      chk($sformatf("lw_req%0d", c), dmem_req, 1);
      chk($sformatf("lw_addr%0d", c), dmem_addr, 32'h40);
      chk($sformatf("lw_we%0d", c), dmem_we, 0);
      chk($sformatf("lw_bubble%0d", c), MEM_WB_valid, 0);
      tick();
    end
    dmem_ready = 1'b0;
    chk("lw_valid", MEM_WB_valid, 1);
    chk("lw_rdata", MEM_WB_read_data, 32'hDEADBEEF);
    chk("lw_rwp", reg_write_pause, 1);
    chk("lw_dest", MEM_WB_dest_reg, 5);
    chk("lw_m2r", MEM_WB_memtoreg, 1);
    chk("lw_stall_done", mem_stall, 0);
    chk("lw_req_done", dmem_req, 0);

    // Flush in IDLE: store becomes a bubble, no request
    drive(1, 0, 0, 0, 1, 32'h60, 32'h77, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    chk("iflush_req", dmem_req, 0);
    chk("iflush_valid", MEM_WB_valid, 0);
    chk("iflush_stall", mem_stall, 0);

    // SW [0x80] <- 0x1234, flush in WAIT cycle 1, ready in cycle 2
    drive(1, 0, 0, 0, 1, 32'h80, 32'h1234, 5'd0);
    tick();
    flush = 1'b1;
    chk("sw_we1", dmem_we, 1);
    chk("sw_wdata1", dmem_wdata, 32'h1234);
    chk("sw_req1", dmem_req, 1);
    tick();
    flush = 1'b0; dmem_ready = 1'b1;
    chk("sw_we2", dmem_we, 1);
    chk("sw_wdata2", dmem_wdata, 32'h1234);
    chk("sw_addr2", dmem_addr, 32'h80);
    chk("sw_stall2", mem_stall, 1);
    tick();
    dmem_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    chk("sw_valid", MEM_WB_valid, 0);
    chk("sw_rwp", reg_write_pause, 0);
    chk("sw_req_done", dmem_req, 0);

    // LW $4 killed by flush coinciding with ready
    drive(1, 1, 1, 1, 0, 32'h50, 32'h0, 5'd4);
    tick();
    flush = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h0BAD;
    tick();
    flush = 1'b0; dmem_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    chk("kflush_valid", MEM_WB_valid, 0);
    chk("kflush_rwp", reg_write_pause, 0);
    chk("kflush_stall", mem_stall, 0);

    // ADDI $0: valid but no register write
    drive(1, 1, 0, 0, 0, 32'h7, 32'h0, 5'd0);
    tick();
    chk("addi0_valid", MEM_WB_valid, 1);
    chk("addi0_rwp", reg_write_pause, 0);
    chk("addi0_alu", MEM_WB_alu_result, 32'h7);

    // Back-to-back loads, each ready in its first WAIT cycle
    drive(1, 1, 1, 1, 0, 32'h100, 32'h0, 5'd6);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'hA1;
    chk("b2b1_stall", mem_stall, 1);
    chk("b2b1_addr", dmem_addr, 32'h100);
    tick();
    dmem_ready = 1'b0;
    drive(1, 1, 1, 1, 0, 32'h104, 32'h0, 5'd7);
    chk("b2b1_valid", MEM_WB_valid, 1);
    chk("b2b1_rdata", MEM_WB_read_data, 32'hA1);
    chk("b2b1_dest", MEM_WB_dest_reg, 6);
    chk("b2b1_idle", mem_stall, 0);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'hB2;
    chk("b2b2_req", dmem_req, 1);
    chk("b2b2_addr", dmem_addr, 32'h104);
    tick();
    dmem_ready = 1'b0;
    drive(1, 1, 1, 1, 0, 32'h108, 32'h0, 5'd8);
    chk("b2b2_valid", MEM_WB_valid, 1);
    chk("b2b2_rdata", MEM_WB_read_data, 32'hB2);
    chk("b2b2_dest", MEM_WB_dest_reg, 7);
    tick();
    chk("lw3_req", dmem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    chk("wrst_req", dmem_req, 0);
    chk("wrst_stall", mem_stall, 0);
    chk("wrst_valid", MEM_WB_valid, 0);
    chk("wrst_addr", dmem_addr, 0);
    chk("wrst_rdata", MEM_WB_read_data, 0);
    chk("wrst_dest", MEM_WB_dest_reg, 0);

    // Memory never ready
    drive(1, 1, 1, 1, 0, 32'h200, 32'h0, 5'd2);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
`ifdef MEM_WB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_stall%0d", c), mem_stall, 1);
      chk($sformatf("to_err%0d", c), mem_err, 0);
      tick();
    end
    chk("to_err_pulse", mem_err, 1);
    chk("to_stall_done", mem_stall, 0);
    chk("to_req_done", dmem_req, 0);
    chk("to_valid", MEM_WB_valid, 0);
    tick();
    chk("to_err_clear", mem_err, 0);
`else
    for (int c = 1; c <= 20; c++) tick();
    chk("hold_req", dmem_req, 1);
    chk("hold_stall", mem_stall, 1);
    chk("hold_err", mem_err, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'h5A5A;
    tick();
    dmem_ready = 1'b0;
    chk("hold_valid", MEM_WB_valid, 1);
    chk("hold_rdata", MEM_WB_read_data, 32'h5A5A);
    chk("hold_stall_done", mem_stall, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
